lif_array: RTL and testbench
============================

# lif_array

Parametrised bank of N leaky-integrate-and-fire neurons sharing one clock, with run-time configurable threshold, leak shift and refractory period. It succeeds the single fixed-width neuron. Each neuron resets its membrane on spike, ignores input during refractory, and saturates instead of wrapping. It sits between the input-current encoder and the spike router, and exposes a saturating spike-event counter for on-chip debug and readout.

## Interface

Parameters:
- N, 4, number of neurons (channels), ≥1
- W, 8, membrane/current/threshold width in bits
- LEAK_W, 3, width of the leak-shift field
- REF_W, 4, width of the refractory counter
- CNT_W, 16, width of the spike-event counter
- DEF_THRESH, 200, threshold after reset
- DEF_LEAK, 1, leak shift after reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  integration step strobe; all neurons advance when high
- current  in  N*W  per-channel input; channel i at [i*W +: W], unsigned
- cfg_we  in  1  write enable for the three config fields
- cfg_threshold  in  W  spike threshold, unsigned
- cfg_leak_shift  in  LEAK_W  right-shift applied to membrane each step
- cfg_refrac  in  REF_W  refractory length in steps
- state  out  N*W  registered membrane potentials, same packing as current
- spike  out  N  registered one-cycle spike pulses
- spike_any  out  1  registered OR of spike
- spike_count  out  CNT_W  saturating total spike events since reset

## Operation

- Reset (async, rst_n low): state=0, spike=0, spike_any=0, spike_count=0, all refractory counters=0, threshold=DEF_THRESH, leak=DEF_LEAK, refrac=0. Reset mid-step discards the step.
- Config: on cfg_we, the three fields load at the clock edge. A step in the same cycle uses the old values.
- Per neuron i, on a cycle with in_valid=1:
  - If ref_i≠0: ref_i decrements, state_i stays 0, and spike_i=0. current_i is ignored.
  - Otherwise, compute sum = (state_i >> leak) + current_i in W+1 bits. Next = min(sum, 2^W−1), so the result saturates and never wraps. A leak of W or more makes the shifted term 0.
  - If next ≥ threshold: spike_i=1, state_i=0, ref_i=refrac.
  - Otherwise: spike_i=0, state_i=next.
- On a cycle with in_valid=0: state and refractory counters hold, and spike=0.
- Threshold 0 means every non-refractory step spikes.
- spike_count adds popcount(spike_next) on each step and saturates at 2^CNT_W−1. It is unaffected by cfg_we.

## Timing

- Latency: current sampled at edge k with in_valid produces state and spike visible after edge k. spike is high for exactly one cycle per spike event.
- spike_any follows spike in the same cycle. spike_count includes the event in the same cycle as spike.
- No backpressure: in_valid may be high every cycle.
- Refractory of R blocks exactly R in_valid steps after a spike step, counting steps rather than cycles.

## Structure

- Package lif_pkg holds:
  - the saturating add function sat_add(a, b, W)
  - the default constants (DEF_THRESH, DEF_LEAK)
  - the per-neuron config struct (threshold, leak, refrac)
- Sub-module lif_cell is one neuron: state register, refractory counter and spike register, parametrised by W, LEAK_W and REF_W. lif_array instantiates N of these with a generate loop.
- The top level holds the config registers, the popcount and the saturating counter.

## Test plan

- Defaults (W=8, threshold 200, leak 1, refrac 0), channel 0 current 101 every cycle:
  - state goes 101, 151, 176, 189, 195, 198.
  - Step 7 produces spike[0]=1 with state 0.
  - spike_count=1.
- Same setup with current 100:
  - state converges to 199 and holds.
  - No spike ever occurs.
- Saturation: threshold 255, leak 1, current 200:
  - Step 1 gives state 200.
  - Step 2 sums to 300, saturates to 255 and spikes. A wrapping implementation would give 44 and fail.
- Refractory: refrac 3, threshold 200, current 255:
  - Spikes on steps 1, 5 and 9.
  - Steps 2–4 show state 0 and no spike.
  - Gaps with in_valid=0 in the middle do not shorten the refractory period.
- cfg_we with in_valid in the same cycle: that step uses the old threshold and the following step uses the new one. An N-channel simultaneous spike on all 4 channels adds 4 to spike_count and sets spike_any=1. The counter is forced near 2^CNT_W−1 and checked to saturate.
- Async reset asserted mid-run with nonzero state, a pending refractory period and spike=1: all outputs become 0 immediately without waiting for a clock edge. The config returns to 200/1/0.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types, defaults and the saturating adder for the leaky-integrate-and-fire neuron bank.
package lif_pkg;

  localparam int unsigned LIF_W      = 8;
  localparam int unsigned LIF_LEAK_W = 3;
  localparam int unsigned LIF_REF_W  = 4;

  localparam int unsigned DEF_THRESH = 200;
  localparam int unsigned DEF_LEAK   = 1;

  typedef struct packed {
    logic [LIF_W-1:0]      threshold;
    logic [LIF_LEAK_W-1:0] leak;
    logic [LIF_REF_W-1:0]  refrac;
  } lif_cfg_t;

  // Unsigned a + b clamped to 2^w - 1; callers truncate the result to w bits.
  function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] max_v;
    sum   = {1'b0, a} + {1'b0, b};
    max_v = (33'd1 << w) - 33'd1;
    return (sum > max_v) ? max_v : sum;
  endfunction

endpackage

// File: rtl/lif_cell.sv
// One LIF neuron: membrane register, refractory counter and registered spike pulse.
module lif_cell
  import lif_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned LEAK_W = 3,
  parameter int unsigned REF_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [W-1:0]      current,
  input  logic [W-1:0]      threshold,
  input  logic [LEAK_W-1:0] leak_shift,
  input  logic [REF_W-1:0]  refrac,
  output logic [W-1:0]      state,
  output logic              spike,
  output logic              spike_nxt_c
);

  logic [W-1:0]     state_q, state_d;
  logic [REF_W-1:0] ref_q, ref_d;
  logic             spike_q, spike_d;
  logic [W-1:0]     shifted_c;
  logic [W-1:0]     sum_c;

  // A logical shift by W or more already yields zero, so large leaks need no special case.
  always_comb begin
    state_d   = state_q;
    ref_d     = ref_q;
    spike_d   = 1'b0;
    shifted_c = state_q >> leak_shift;
    sum_c     = W'(sat_add(32'(shifted_c), 32'(current), W));
    if (in_valid) begin
      if (ref_q != '0) begin
        ref_d   = ref_q - REF_W'(1);
        state_d = '0;
      end else if (sum_c >= threshold) begin
        spike_d = 1'b1;
        state_d = '0;
        ref_d   = refrac;
      end else begin
        state_d = sum_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      ref_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      spike_q <= spike_d;
    end
  end

  assign state       = state_q;
  assign spike       = spike_q;
  assign spike_nxt_c = spike_d;

endmodule

// File: rtl/lif_array.sv
// Bank of N LIF neurons with shared run-time config and a saturating spike-event counter.
module lif_array
  import lif_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned W          = LIF_W,
  parameter int unsigned LEAK_W     = LIF_LEAK_W,
  parameter int unsigned REF_W      = LIF_REF_W,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DEF_THRESH = lif_pkg::DEF_THRESH,
  parameter int unsigned DEF_LEAK   = lif_pkg::DEF_LEAK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [N*W-1:0]    current,
  input  logic              cfg_we,
  input  logic [W-1:0]      cfg_threshold,
  input  logic [LEAK_W-1:0] cfg_leak_shift,
  input  logic [REF_W-1:0]  cfg_refrac,
  output logic [N*W-1:0]    state,
  output logic [N-1:0]      spike,
  output logic              spike_any,
  output logic [CNT_W-1:0]  spike_count
);

  localparam int unsigned POP_W = $clog2(N + 1);

  lif_cfg_t         cfg_q, cfg_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             spike_any_q, spike_any_d;
  logic [N-1:0]     spike_nxt_c;
  logic [POP_W-1:0] pop_c;

  // Config loads at the edge, so a step in the same cycle still sees the old fields.
  always_comb begin
    cfg_d = cfg_q;
    if (cfg_we) begin
      cfg_d.threshold = cfg_threshold;
      cfg_d.leak      = cfg_leak_shift;
      cfg_d.refrac    = cfg_refrac;
    end
  end

  // Counting next-cycle spikes keeps the counter aligned with the registered spike outputs.
  always_comb begin
    pop_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pop_c = pop_c + POP_W'(spike_nxt_c[i]);
    end
    count_d     = CNT_W'(sat_add(32'(count_q), 32'(pop_c), CNT_W));
    spike_any_d = |spike_nxt_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q.threshold <= W'(DEF_THRESH);
      cfg_q.leak      <= LEAK_W'(DEF_LEAK);
      cfg_q.refrac    <= '0;
      count_q         <= '0;
      spike_any_q     <= 1'b0;
    end else begin
      cfg_q       <= cfg_d;
      count_q     <= count_d;
      spike_any_q <= spike_any_d;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_cell
    lif_cell #(
      .W      (W),
      .LEAK_W (LEAK_W),
      .REF_W  (REF_W)
    ) u_cell (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .current     (current[g*W +: W]),
      .threshold   (cfg_q.threshold),
      .leak_shift  (cfg_q.leak),
      .refrac      (cfg_q.refrac),
      .state       (state[g*W +: W]),
      .spike       (spike[g]),
      .spike_nxt_c (spike_nxt_c[g])
    );
  end

  assign spike_any   = spike_any_q;
  assign spike_count = count_q;

endmodule

// File: tb/tb_lif_array.sv
// Directed self-checking bench for lif_array; a second instance with a 3-bit counter covers saturation.
module tb_lif_array;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic [N*W-1:0] current = '0;
  logic           cfg_we = 1'b0;
  logic [W-1:0]   cfg_threshold = '0;
  logic [2:0]     cfg_leak_shift = '0;
  logic [3:0]     cfg_refrac = '0;
  logic [N*W-1:0] state;
  logic [N-1:0]   spike;
  logic           spike_any;
  logic [15:0]    spike_count;
  logic [N*W-1:0] s2_state;
  logic [N-1:0]   s2_spike;
  logic           s2_any;
  logic [2:0]     s2_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lif_array u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .current(current),
    .cfg_we(cfg_we), .cfg_threshold(cfg_threshold), .cfg_leak_shift(cfg_leak_shift),
    .cfg_refrac(cfg_refrac), .state(state), .spike(spike), .spike_any(spike_any),
    .spike_count(spike_count)
  );

  lif_array #(.CNT_W(3)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .current(current),
    .cfg_we(cfg_we), .cfg_threshold(cfg_threshold), .cfg_leak_shift(cfg_leak_shift),
    .cfg_refrac(cfg_refrac), .state(s2_state), .spike(s2_spike), .spike_any(s2_any),
    .spike_count(s2_count)
  );

  function automatic int ch(input int i);
    return int'(state[i*W +: W]);
  endfunction

  task automatic set_cur(input int i, input int v);
    current[i*W +: W] = W'(v);
  endtask

  task automatic step();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic configure(input int th, input int lk, input int rf);
    cfg_threshold  = W'(th);
    cfg_leak_shift = 3'(lk);
    cfg_refrac     = 4'(rf);
    cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    current  = '0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (state !== '0 || spike !== '0 || spike_any !== 1'b0 || spike_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: state=%h spike=%b any=%b count=%0d required all zero",
               state, spike, spike_any, spike_count);
    end
    checks++;
    if (s2_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_sat_count: got %0d required 0", s2_count);
    end
  endtask

  task automatic test_defaults_spike();
    int exp_s[6] = '{101, 151, 176, 189, 195, 198};
    apply_reset();
    set_cur(0, 101);
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (ch(0) !== exp_s[k] || spike !== '0) begin
        errors++;
        $display("FAIL defaults_step%0d: state=%0d spike=%b required state=%0d spike=0",
                 k + 1, ch(0), spike, exp_s[k]);
      end
    end
    step();
    checks++;
    if (spike !== 4'b0001 || ch(0) !== 0 || spike_any !== 1'b1 || spike_count !== 16'd1) begin
      errors++;
      $display("FAIL defaults_spike7: spike=%b state=%0d any=%b count=%0d required 0001/0/1/1",
               spike, ch(0), spike_any, spike_count);
    end
    step();
    checks++;
    if (spike !== '0 || spike_any !== 1'b0 || ch(0) !== 101 || spike_count !== 16'd1) begin
      errors++;
      $display("FAIL defaults_after_spike: spike=%b any=%b state=%0d count=%0d required 0/0/101/1",
               spike, spike_any, ch(0), spike_count);
    end
  endtask

  task automatic test_converge();
    int exp_s[9] = '{100, 150, 175, 187, 193, 196, 198, 199, 199};
    int spiked = 0;
    apply_reset();
    set_cur(0, 100);
    for (int k = 0; k < 20; k++) begin
      step();
      if (spike !== '0) spiked++;
      if (k < 9) begin
        checks++;
        if (ch(0) !== exp_s[k]) begin
          errors++;
          $display("FAIL converge_step%0d: state=%0d required %0d", k + 1, ch(0), exp_s[k]);
        end
      end
    end
    checks++;
    if (spiked != 0 || ch(0) !== 199 || spike_count !== 16'd0) begin
      errors++;
      $display("FAIL converge_nospike: spikes=%0d state=%0d count=%0d required 0/199/0",
               spiked, ch(0), spike_count);
    end
    idle(3);
    checks++;
    if (ch(0) !== 199 || spike !== '0) begin
      errors++;
      $display("FAIL idle_hold: state=%0d spike=%b required 199/0", ch(0), spike);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    configure(255, 1, 0);
    set_cur(0, 200);
    step();
    checks++;
    if (ch(0) !== 200 || spike !== '0) begin
      errors++;
      $display("FAIL sat_step1: state=%0d spike=%b required 200/0", ch(0), spike);
    end
    step();
    checks++;
    if (ch(0) !== 0 || spike !== 4'b0001) begin
      errors++;
      $display("FAIL sat_step2: state=%0d spike=%b required 0/0001", ch(0), spike);
    end
  endtask

  task automatic test_refractory();
    logic exp_sp[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    configure(200, 1, 3);
    set_cur(0, 255);
    for (int k = 0; k < 9; k++) begin
      step();
      checks++;
      if (spike[0] !== exp_sp[k] || ch(0) !== 0) begin
        errors++;
        $display("FAIL refrac_step%0d: spike=%b state=%0d required spike=%b state=0",
                 k + 1, spike[0], ch(0), exp_sp[k]);
      end
      if (k == 5) begin
        idle(4);
        checks++;
        if (spike !== '0 || ch(0) !== 0) begin
          errors++;
          $display("FAIL refrac_gap: spike=%b state=%0d required 0/0", spike, ch(0));
        end
      end
    end
    checks++;
    if (spike_count !== 16'd3) begin
      errors++;
      $display("FAIL refrac_count: got %0d required 3", spike_count);
    end
  endtask

  task automatic test_cfg_same_cycle();
    apply_reset();
    set_cur(0, 150);
    cfg_threshold = 8'd100; cfg_leak_shift = 3'd1; cfg_refrac = 4'd0;
    cfg_we = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (spike !== '0 || ch(0) !== 150) begin
      errors++;
      $display("FAIL cfg_old_thresh: spike=%b state=%0d required 0/150", spike, ch(0));
    end
    step();
    checks++;
    if (spike !== 4'b0001 || ch(0) !== 0) begin
      errors++;
      $display("FAIL cfg_new_thresh: spike=%b state=%0d required 0001/0", spike, ch(0));
    end
  endtask

  task automatic test_all_spike_sat();
    int exp_c[3]  = '{4, 8, 12};
    int exp_c2[3] = '{4, 7, 7};
    apply_reset();
    for (int i = 0; i < int'(N); i++) set_cur(i, 255);
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (spike !== 4'hF || spike_any !== 1'b1 || spike_count !== 16'(exp_c[k]) ||
          s2_count !== 3'(exp_c2[k])) begin
        errors++;
        $display("FAIL all_spike_step%0d: spike=%b any=%b count=%0d sat=%0d required F/1/%0d/%0d",
                 k + 1, spike, spike_any, spike_count, s2_count, exp_c[k], exp_c2[k]);
      end
    end
  endtask

  task automatic test_threshold_zero();
    apply_reset();
    configure(0, 1, 0);
    step();
    checks++;
    if (spike !== 4'hF || spike_count !== 16'd4 || state !== '0) begin
      errors++;
      $display("FAIL thresh_zero: spike=%b count=%0d state=%h required F/4/0",
               spike, spike_count, state);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    configure(250, 1, 3);
    set_cur(0, 255);
    set_cur(1, 50);
    step();
    checks++;
    if (spike !== 4'b0001 || ch(1) !== 50) begin
      errors++;
      $display("FAIL pre_reset: spike=%b state1=%0d required 0001/50", spike, ch(1));
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (state !== '0 || spike !== '0 || spike_any !== 1'b0 || spike_count !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: state=%h spike=%b any=%b count=%0d required all zero",
               state, spike, spike_any, spike_count);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    set_cur(1, 101);
    step();
    checks++;
    if (spike !== 4'b0001 || ch(1) !== 101) begin
      errors++;
      $display("FAIL post_reset_step1: spike=%b state1=%0d required 0001/101", spike, ch(1));
    end
    step();
    checks++;
    if (spike !== 4'b0001 || ch(1) !== 151) begin
      errors++;
      $display("FAIL post_reset_defaults: spike=%b state1=%0d required 0001/151", spike, ch(1));
    end
  endtask

  initial begin
    test_reset();
    test_defaults_spike();
    test_converge();
    test_saturation();
    test_refractory();
    test_cfg_same_cycle();
    test_all_spike_sat();
    test_threshold_zero();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
